pattern_scan_ctrl: RTL and testbench
====================================

PATTERN_SCAN_CTRL -- requirements
Module: pattern_scan_ctrl

Interface
REQ-001 Parameter DATA_W, default 8, width of each input word, serialized MSB first.
REQ-002 Parameter PAT_W, default 7, pattern length in bits.
REQ-003 Parameter CNT_W, default 8, width of match_cnt.
REQ-004 Port clk, input, 1, sole clock; all state updates on rising edge.
REQ-005 Port reset, input, 1, synchronous active-high reset.
REQ-006 Port cfg_we, input, 1, pattern write strobe; honored only in IDLE.
REQ-007 Port cfg_pattern, input, PAT_W, pattern value written when cfg_we is honored.
REQ-008 Port start, input, 1, begins a scan; honored only in IDLE.
REQ-009 Port word_count, input, 8, number of words in the scan; latched when start is honored.
REQ-010 Port in_valid, input, 1, word available from upstream.
REQ-011 Port in_data, input, DATA_W, word to serialize.
REQ-012 Port in_ready, output, 1, block accepts a word this cycle.
REQ-013 Port bit_out, output, 1, serial bit currently being scanned.
REQ-014 Port bit_valid, output, 1, bit_out is valid this cycle.
REQ-015 Port match, output, 1, one-cycle pulse per pattern occurrence.
REQ-016 Port match_cnt, output, CNT_W, matches counted since last honored start.
REQ-017 Port busy, output, 1, high in every state except IDLE.
REQ-018 Port done, output, 1, one-cycle pulse at scan end.

Function
REQ-019 The FSM SHALL have exactly four states: IDLE, WAIT, SHIFT and DONE.
REQ-020 IDLE: start SHALL latch word_count, clear match_cnt, history and bits_seen, and move to DONE if word_count==0, else WAIT.
REQ-021 IDLE: cfg_we SHALL load cfg_pattern into the pattern register. If cfg_we and start occur in the same cycle, the new pattern SHALL apply to that scan.
REQ-022 WAIT: in_ready SHALL be 1. A transfer occurs when in_valid&in_ready; it SHALL capture in_data, set bit index to DATA_W-1 and move to SHIFT.
REQ-023 In_ready SHALL be 0 in IDLE, SHIFT and DONE.
REQ-024 SHIFT: for DATA_W consecutive cycles, bit_out SHALL equal word[index] and bit_valid SHALL be 1. Index decrements each cycle.
REQ-025 Each SHIFT cycle, history SHALL shift in bit_out at the LSB: {history[PAT_W-2:0], bit_out}.
REQ-026 Each SHIFT cycle, bits_seen SHALL increment, saturating at PAT_W.
REQ-027 A match SHALL be detected in a SHIFT cycle when {history[PAT_W-2:0], bit_out}==pattern and bits_seen+1>=PAT_W.
REQ-028 Match SHALL pulse high in the cycle after detection. Overlapping occurrences each count.
REQ-029 History and bits_seen SHALL persist across word boundaries within one scan.
REQ-030 Match_cnt SHALL increment by 1 per detection and saturate at 2^CNT_W-1.
REQ-031 SHIFT at index 0 SHALL decrement the remaining-word count and go to DONE if it was 1, else WAIT.
REQ-032 DONE: done SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE. Match_cnt SHALL hold until the next honored start.
REQ-033 Start and cfg_we outside IDLE SHALL be ignored.
REQ-034 In WAIT with in_valid=0: bit_valid SHALL be 0 and history, bits_seen and index SHALL hold.
REQ-035 Latency: the first bit SHALL appear in the cycle after the handshake; bit_valid SHALL be 0 in all non-SHIFT states.

Reset
REQ-036 Reset SHALL be sampled only on the rising clock edge and SHALL override every other input, including mid-scan.
REQ-037 On reset: state=IDLE, pattern=7'b1010111, history=0, bits_seen=0, remaining count=0, match_cnt=0.
REQ-038 On reset: in_ready, bit_out, bit_valid, match, busy and done SHALL all be 0.

Verification
REQ-039 Default pattern; start with word_count=1; word 0x57 sent the cycle after start -> bits 0,1,0,1,0,1,1,1 on bit_out over 8 cycles; a single match pulse and done both one cycle after the last bit; match_cnt=1.
REQ-040 cfg_we with pattern 7'b0000000, then word_count=1, word 0x00 -> no match during the first 6 bits; matches after bits 7 and 8; match_cnt=2.
REQ-041 Pattern 7'b0000000, word_count=40, forty 0x00 words -> 314 detections; match_cnt saturates at 255 with no wrap.
REQ-042 Word_count=0 -> DONE the cycle after start; done pulses once; match_cnt=0; in_ready never asserted.
REQ-043 In_valid held low 5 cycles in WAIT -> in_ready=1 and bit_valid=0 throughout, no history change. Start and cfg_we pulsed during SHIFT -> ignored; pattern and count unchanged.
REQ-044 Reset asserted mid-SHIFT of a 3-word scan -> next cycle in IDLE with every output 0 and pattern back to 7'b1010111. A new scan then behaves per REQ-039.

Source files
------------

// File: rtl/pattern_scan_ctrl.sv
// rtl/pattern_scan_ctrl.sv - serializes words MSB first and counts pattern occurrences in the bit stream
module pattern_scan_ctrl #(
    parameter int DATA_W = 8,
    parameter int PAT_W  = 7,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_we,
    input  logic [PAT_W-1:0]  cfg_pattern,
    input  logic              start,
    input  logic [7:0]        word_count,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              bit_out,
    output logic              bit_valid,
    output logic              match,
    output logic [CNT_W-1:0]  match_cnt,
    output logic              busy,
    output logic              done
);

    localparam int IDX_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int SEEN_W = $clog2(PAT_W + 1);
    localparam logic [PAT_W-1:0]  RST_PAT  = PAT_W'(7'b1010111);
    localparam logic [IDX_W-1:0]  IDX_TOP  = IDX_W'(DATA_W - 1);
    localparam logic [SEEN_W-1:0] SEEN_MAX = SEEN_W'(PAT_W);
    localparam logic [SEEN_W-1:0] SEEN_ARM = SEEN_W'(PAT_W - 1);

    typedef enum logic [1:0] {IDLE, WAIT, SHIFT, DONE} state_t;

    state_t             state_q, state_d;
    logic [PAT_W-1:0]   pattern_q, pattern_d;
    logic [DATA_W-1:0]  word_q, word_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [7:0]         rem_q, rem_d;
    logic [PAT_W-1:0]   hist_q, hist_d;
    logic [SEEN_W-1:0]  seen_q, seen_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               match_q, match_d;

    logic               cur_bit;
    logic [PAT_W-1:0]   shift_hist;
    logic               hit;

    always_comb begin
        state_d    = state_q;
        pattern_d  = pattern_q;
        word_d     = word_q;
        idx_d      = idx_q;
        rem_d      = rem_q;
        hist_d     = hist_q;
        seen_d     = seen_q;
        cnt_d      = cnt_q;
        match_d    = 1'b0;
        cur_bit    = word_q[idx_q];
        shift_hist = {hist_q[PAT_W-2:0], cur_bit};
        // Only a full window of PAT_W bits from this scan may count as a match.
        hit        = (state_q == SHIFT) && (shift_hist == pattern_q) && (seen_q >= SEEN_ARM);

        case (state_q)
            IDLE: begin
                if (cfg_we) begin
                    pattern_d = cfg_pattern;
                end
                if (start) begin
                    rem_d   = word_count;
                    cnt_d   = '0;
                    hist_d  = '0;
                    seen_d  = '0;
                    state_d = (word_count == 8'd0) ? DONE : WAIT;
                end
            end
            WAIT: begin
                if (in_valid) begin
                    word_d  = in_data;
                    idx_d   = IDX_TOP;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                hist_d = shift_hist;
                if (seen_q != SEEN_MAX) begin
                    seen_d = seen_q + 1'b1;
                end
                if (hit) begin
                    match_d = 1'b1;
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                if (idx_q == '0) begin
                    rem_d   = rem_q - 8'd1;
                    state_d = (rem_q == 8'd1) ? DONE : WAIT;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            pattern_q <= RST_PAT;
            word_q    <= '0;
            idx_q     <= '0;
            rem_q     <= '0;
            hist_q    <= '0;
            seen_q    <= '0;
            cnt_q     <= '0;
            match_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            word_q    <= word_d;
            idx_q     <= idx_d;
            rem_q     <= rem_d;
            hist_q    <= hist_d;
            seen_q    <= seen_d;
            cnt_q     <= cnt_d;
            match_q   <= match_d;
        end
    end

    assign in_ready  = (state_q == WAIT);
    assign bit_valid = (state_q == SHIFT);
    assign bit_out   = (state_q == SHIFT) & word_q[idx_q];
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign match     = match_q;
    assign match_cnt = cnt_q;

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// tb/tb_pattern_scan_ctrl.sv - randomized scans checked against a bit-stream reference model
module tb_pattern_scan_ctrl;

    localparam int DATA_W = 8;
    localparam int PAT_W  = 7;
    localparam int CNT_W  = 8;
    localparam logic [PAT_W-1:0] DEF_PAT = 7'b1010111;

    logic              clk = 1'b0;
    logic              reset;
    logic              cfg_we;
    logic [PAT_W-1:0]  cfg_pattern;
    logic              start;
    logic [7:0]        word_count;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              bit_out;
    logic              bit_valid;
    logic              match;
    logic [CNT_W-1:0]  match_cnt;
    logic              busy;
    logic              done;

    pattern_scan_ctrl #(.DATA_W(DATA_W), .PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .start(start), .word_count(word_count), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .bit_out(bit_out), .bit_valid(bit_valid), .match(match),
        .match_cnt(match_cnt), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [PAT_W-1:0]  model_pat;
    bit                pending_match;
    logic [DATA_W-1:0] wq[$];
    bit                bitq[$];
    bit                detq[$];
    int                exp_cnt;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Outputs seen at a negedge; match must reflect the detection made one cycle earlier.
    task automatic cycle_check(input string tag, input bit e_ready, input bit e_bv, input bit e_bit,
                               input bit e_done, input bit e_busy, input bit det);
        check_val({tag, "_ready"}, 32'(in_ready), 32'(e_ready));
        check_val({tag, "_bv"}, 32'(bit_valid), 32'(e_bv));
        if (e_bv) check_val({tag, "_bit"}, 32'(bit_out), 32'(e_bit));
        check_val({tag, "_done"}, 32'(done), 32'(e_done));
        check_val({tag, "_busy"}, 32'(busy), 32'(e_busy));
        check_val({tag, "_match"}, 32'(match), 32'(pending_match));
        pending_match = det;
    endtask

    // Expected bit stream, detection positions and final count straight from the scan rules.
    task automatic build_model();
        int total;
        bitq.delete();
        detq.delete();
        foreach (wq[i])
            for (int b = DATA_W - 1; b >= 0; b--) bitq.push_back(wq[i][b]);
        total = 0;
        for (int p = 0; p < bitq.size(); p++) begin
            bit hit;
            hit = (p >= PAT_W - 1);
            if (hit)
                for (int j = 0; j < PAT_W; j++)
                    if (bitq[p - PAT_W + 1 + j] != model_pat[PAT_W - 1 - j]) hit = 0;
            detq.push_back(hit);
            if (hit) total++;
        end
        exp_cnt = (total > 255) ? 255 : total;
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
    task automatic run_scan(input string tag, input bit do_cfg, input logic [PAT_W-1:0] cfg_val,
                            input bit noisy, input int min_gap, input int max_gap);
        int pos;
        int gap;
        cfg_we      = do_cfg;
        cfg_pattern = cfg_val;
        start       = 1'b1;
        word_count  = 8'(wq.size());
        if (do_cfg) model_pat = cfg_val;
        build_model();
        @(negedge clk);
        start  = 1'b0;
        cfg_we = 1'b0;
        pending_match = 0;
        pos = 0;
        foreach (wq[i]) begin
            gap = $urandom_range(max_gap, min_gap);
            for (int g = 0; g < gap; g++) begin
                cycle_check($sformatf("%s_w%0d", tag, i), 1, 0, 0, 0, 1, 0);
                in_valid = 1'b0;
                in_data  = DATA_W'($urandom);
                @(negedge clk);
            end
            cycle_check($sformatf("%s_hs%0d", tag, i), 1, 0, 0, 0, 1, 0);
            in_valid = 1'b1;
            in_data  = wq[i];
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = DATA_W'($urandom);
            for (int b = 0; b < DATA_W; b++) begin
                cycle_check($sformatf("%s_b%0d", tag, pos), 0, 1, bitq[pos], 0, 1, detq[pos]);
                if (noisy) begin
                    start       = 1'($urandom);
                    cfg_we      = 1'($urandom);
                    cfg_pattern = PAT_W'($urandom);
                    word_count  = 8'($urandom);
                end
                pos++;
                @(negedge clk);
            end
            start  = 1'b0;
            cfg_we = 1'b0;
        end
        cycle_check({tag, "_done"}, 0, 0, 0, 1, 1, 0);
        @(negedge clk);
        cycle_check({tag, "_idle"}, 0, 0, 0, 0, 0, 0);
        check_val({tag, "_cnt"}, 32'(match_cnt), 32'(exp_cnt));
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_ready"}, 32'(in_ready), 0);
        check_val({tag, "_bit"}, 32'(bit_out), 0);
        check_val({tag, "_bv"}, 32'(bit_valid), 0);
        check_val({tag, "_match"}, 32'(match), 0);
        check_val({tag, "_busy"}, 32'(busy), 0);
        check_val({tag, "_done"}, 32'(done), 0);
        check_val({tag, "_cnt"}, 32'(match_cnt), 0);
    endtask

    initial begin
        reset = 1'b1; cfg_we = 1'b0; cfg_pattern = '0; start = 1'b0;
        word_count = 8'd0; in_valid = 1'b0; in_data = '0;
        pending_match = 0;
        repeat (2) @(negedge clk);
        check_all_zero("rst");
        reset = 1'b0;
        model_pat = DEF_PAT;

        wq = '{8'h57};
        run_scan("d57", 0, '0, 0, 0, 0);
        check_val("d57_cnt1", 32'(match_cnt), 1);

        wq = '{8'h00};
        run_scan("zero1", 1, 7'h00, 0, 0, 0);
        check_val("zero1_cnt2", 32'(match_cnt), 2);

        wq.delete();
        for (int i = 0; i < 40; i++) wq.push_back(8'h00);
        run_scan("sat", 0, '0, 0, 0, 1);
        check_val("sat_cnt255", 32'(match_cnt), 255);

        wq.delete();
        run_scan("wc0", 0, '0, 0, 0, 0);
        check_val("wc0_cnt", 32'(match_cnt), 0);

        wq = '{8'h3C, 8'hA5};
        run_scan("noise", 1, 7'b0111100, 1, 5, 5);
        wq = '{8'hF0, 8'h78, 8'h3C};
        run_scan("after_noise", 0, '0, 0, 0, 2);

        for (int t = 0; t < 30; t++) begin
            int n;
            logic [PAT_W-1:0] p;
            n = $urandom_range(4, 0);
            case ($urandom_range(3, 0))
                0: p = '0;
                1: p = '1;
                2: p = 7'b0101010;
                default: p = PAT_W'($urandom);
            endcase
            wq.delete();
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(1, 0) == 1) wq.push_back({DATA_W{1'($urandom)}});
                else if ($urandom_range(1, 0) == 1) wq.push_back(8'h55 ^ {DATA_W{1'($urandom)}});
                else wq.push_back(DATA_W'($urandom));
            end
            run_scan($sformatf("r%0d", t), 1'($urandom), p, 1'($urandom), 0, 3);
        end

        cfg_we = 1'b1; cfg_pattern = '0; start = 1'b1; word_count = 8'd3;
        @(negedge clk);
        cfg_we = 1'b0; start = 1'b0; in_valid = 1'b1; in_data = 8'hFF;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_val("mid_bv", 32'(bit_valid), 1);
        reset = 1'b1;
        @(negedge clk);
        check_all_zero("mid_rst");
        reset = 1'b0;
        model_pat = DEF_PAT;
        pending_match = 0;
        wq = '{8'h57};
        run_scan("post_rst", 0, '0, 0, 0, 0);
        check_val("post_rst_cnt1", 32'(match_cnt), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule
